// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing helpers for the sync_fifo block: ceiling log2,
//               storage depth and occupancy-counter width from ASIZE.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Number of words held by a FIFO with ASIZE-bit pointers.
    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    // Width needed to count 0..DEPTH inclusive (ASIZE+1 bits).
    function automatic int fifo_level_w(input int asize);
        return clog2(fifo_depth(asize) + 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_if
// Description : Producer/consumer bundle of the sync_fifo. The master modport
//               is the side that pushes/pops and programs thresholds; the
//               slave modport is the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
) ();
    logic             flush;
    logic             shift_in;
    logic [DSIZE-1:0] d_in;
    logic             shift_out;
    logic [DSIZE-1:0] d_out;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic             almost_empty;
    logic [ASIZE:0]   af_thresh;
    logic [ASIZE:0]   ae_thresh;
    logic [ASIZE:0]   level;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output flush, shift_in, d_in, shift_out, af_thresh, ae_thresh, clr_err,
        input  d_out, full, almost_full, empty, almost_empty, level,
               overflow, underflow
    );

    modport slave (
        input  flush, shift_in, d_in, shift_out, af_thresh, ae_thresh, clr_err,
        output d_out, full, almost_full, empty, almost_empty, level,
               overflow, underflow
    );
endinterface : sync_fifo_if
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : DSIZE x DEPTH simple dual-port storage, one write port and one
//               read port. SYNC_READ=0 gives a combinational read, SYNC_READ=1
//               a read register loaded only when i_re is high. No reset: the
//               contents are only meaningful once written.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 4,
    parameter bit SYNC_READ = 1'b0
) (
    input  wire              clk,
    input  wire              i_we,
    input  wire  [ASIZE-1:0] i_waddr,
    input  wire  [DSIZE-1:0] i_wdata,
    input  wire              i_re,
    input  wire  [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);
    localparam int c_DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [c_DEPTH];

    // Write port: store the word at the write address on an enabled edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    generate
        if (SYNC_READ) begin : g_sync_read
            logic [DSIZE-1:0] rdata_q;

            // Registered read: the register doubles as the FIFO output stage,
            // so it only moves when the caller asks for the next word.
            always_ff @(posedge clk) begin
                if (i_re) begin
                    rdata_q <= mem_q[i_raddr];
                end
            end

            assign o_rdata = rdata_q;
        end else begin : g_async_read
            // Read enable has no meaning for a combinational read.
            logic unused_re;
            assign unused_re = i_re;
            assign o_rdata   = mem_q[i_raddr];
        end
    endgenerate

endmodule : fifo_ram
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Occupancy is a
//               dedicated counter (never pointer comparison), almost flags
//               are programmable compares on that counter, flush clears the
//               contents, overflow/underflow are sticky until clr_err.
//               PIPELINED=1 registers the RAM read into a prefetch output
//               stage with its own valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 4,
    parameter bit PIPELINED = 1'b0
) (
    input  wire        clk,
    input  wire        res,
    sync_fifo_if.slave bus
);
    localparam int c_DEPTH = fifo_depth(ASIZE);
    localparam int c_LVL_W = fifo_level_w(ASIZE);

    typedef logic [c_LVL_W-1:0] level_t;
    typedef logic [ASIZE-1:0]   ptr_t;

    localparam level_t c_LVL_FULL = level_t'(c_DEPTH);

    // Registered state
    ptr_t   wptr_q;
    ptr_t   wptr_d;
    ptr_t   rptr_q;
    ptr_t   rptr_d;
    level_t level_q;
    level_t level_d;
    logic   overflow_q;
    logic   overflow_d;
    logic   underflow_q;
    logic   underflow_d;

    // Combinational decode
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_pop_acc;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_load;
    logic [DSIZE-1:0] w_ram_rdata;

    assign w_full = (level_q == c_LVL_FULL);

    // flush swallows both requests, so neither can raise an error flag.
    assign w_wr_acc  = bus.shift_in  && !w_full  && !bus.flush;
    assign w_pop_acc = bus.shift_out && !w_empty && !bus.flush;
    assign w_ovf_evt = bus.shift_in  &&  w_full  && !bus.flush;
    assign w_unf_evt = bus.shift_out &&  w_empty && !bus.flush;

    generate
        if (PIPELINED) begin : g_prefetch
            logic   out_valid_q;
            logic   out_valid_d;
            level_t w_ram_cnt;

            // Words still sitting in RAM behind the output register.
            assign w_ram_cnt = level_q - level_t'(out_valid_q);

            // Refill the output stage whenever it is empty or being consumed
            // and the RAM has something queued; this keeps 1 word/cycle.
            assign w_load  = (!out_valid_q || w_pop_acc) && (w_ram_cnt != '0)
                             && !bus.flush;
            assign w_empty = !out_valid_q;

            // Next-state of the output-stage valid bit.
            always_comb begin
                out_valid_d = out_valid_q;
                if (bus.flush) begin
                    out_valid_d = 1'b0;
                end else if (w_load) begin
                    out_valid_d = 1'b1;
                end else if (w_pop_acc) begin
                    out_valid_d = 1'b0;
                end
            end

            // Output-stage valid flop.
            always_ff @(posedge clk or posedge res) begin
                if (res) begin
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= out_valid_d;
                end
            end
        end else begin : g_direct
            // The head of the RAM is the output; the read pointer moves on
            // every accepted pop.
            assign w_load  = w_pop_acc;
            assign w_empty = (level_q == '0);
        end
    endgenerate

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        // A fresh error event in the clearing cycle keeps the flag set.
        overflow_d  = (overflow_q  && !bus.clr_err) || w_ovf_evt;
        underflow_d = (underflow_q && !bus.clr_err) || w_unf_evt;

        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (w_wr_acc) begin
                wptr_d = wptr_q + ptr_t'(1);
            end
            if (w_load) begin
                rptr_d = rptr_q + ptr_t'(1);
            end
            case ({w_wr_acc, w_pop_acc})
                2'b10:   level_d = level_q + level_t'(1);
                2'b01:   level_d = level_q - level_t'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers; reset is asynchronous so outputs clear immediately.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DSIZE     (DSIZE),
        .ASIZE     (ASIZE),
        .SYNC_READ (PIPELINED)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (wptr_q),
        .i_wdata (bus.d_in),
        .i_re    (w_load),
        .i_raddr (rptr_q),
        .o_rdata (w_ram_rdata)
    );

    // Blank the data bus while nothing is valid; this also gives d_out=0
    // out of reset even though the RAM itself is never cleared.
    assign bus.d_out        = w_empty ? '0 : w_ram_rdata;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.level        = level_q;
    assign bus.almost_full  = (level_q >= bus.af_thresh);
    assign bus.almost_empty = (level_q <= bus.ae_thresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. Both PIPELINED variants run
//               side by side on the same stimulus; each has its own occupancy
//               model and expected-data queue. The driver pushes accepted
//               words, the monitor compares the head word and pops on consume.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    sync_fifo_if #(.DSIZE(32), .ASIZE(4)) if0 ();
    sync_fifo_if #(.DSIZE(32), .ASIZE(4)) if1 ();

    sync_fifo #(.DSIZE(32), .ASIZE(4), .PIPELINED(1'b0)) u_dut0 (
        .clk (clk), .res (res), .bus (if0)
    );
    sync_fifo #(.DSIZE(32), .ASIZE(4), .PIPELINED(1'b1)) u_dut1 (
        .clk (clk), .res (res), .bus (if1)
    );

    // Observed outputs, indexable per DUT
    logic [31:0] o_dout [2];
    logic        o_empty[2];
    logic        o_full [2];
    logic        o_af   [2];
    logic        o_ae   [2];
    logic [4:0]  o_level[2];
    logic        o_ovf  [2];
    logic        o_unf  [2];

    assign o_dout[0]  = if0.d_out;        assign o_dout[1]  = if1.d_out;
    assign o_empty[0] = if0.empty;        assign o_empty[1] = if1.empty;
    assign o_full[0]  = if0.full;         assign o_full[1]  = if1.full;
    assign o_af[0]    = if0.almost_full;  assign o_af[1]    = if1.almost_full;
    assign o_ae[0]    = if0.almost_empty; assign o_ae[1]    = if1.almost_empty;
    assign o_level[0] = if0.level;        assign o_level[1] = if1.level;
    assign o_ovf[0]   = if0.overflow;     assign o_ovf[1]   = if1.overflow;
    assign o_unf[0]   = if0.underflow;    assign o_unf[1]   = if1.underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: stored words, occupancy, head visibility, flags
    logic [31:0] exp_q[2][$];
    int          m_cnt[2];
    bit          m_vis[2];
    bit          m_ovf[2];
    bit          m_unf[2];
    int          n_cnt[2];
    bit          n_vis[2];
    bit          n_ovf[2];
    bit          n_unf[2];
    bit          n_flush;

    int  af_t;
    int  ae_t;
    bit  cur_so;
    bit  cur_fl;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input int dut,
                         input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s dut%0d got=%0h expected=%0h @%0t",
                     name, dut, act, exp, $time);
        end
    endtask

    task automatic drive(input bit si, input logic [31:0] di, input bit so,
                         input bit fl, input bit ce);
        if0.shift_in = si; if0.d_in = di; if0.shift_out = so;
        if0.flush = fl; if0.clr_err = ce;
        if1.shift_in = si; if1.d_in = di; if1.shift_out = so;
        if1.flush = fl; if1.clr_err = ce;
        cur_so = so;
        cur_fl = fl;
    endtask

    task automatic set_thr(input int af, input int ae);
        af_t = af;
        ae_t = ae;
        if0.af_thresh = 5'(af); if1.af_thresh = 5'(af);
        if0.ae_thresh = 5'(ae); if1.ae_thresh = 5'(ae);
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            exp_q[m].delete();
            m_cnt[m] = 0; m_vis[m] = 1'b0; m_ovf[m] = 1'b0; m_unf[m] = 1'b0;
        end
    endtask

    // One clock: drive requests, predict the post-edge state, advance.
    // Called and returns at posedge+2.
    task automatic cycle(input bit si, input logic [31:0] di, input bit so,
                         input bit fl, input bit ce);
        drive(si, di, so, fl, ce);
        for (int m = 0; m < 2; m++) begin
            bit wr;
            bit pop;
            bit oe;
            bit ue;
            wr  = si && !fl && (m_cnt[m] < DEPTH);
            pop = so && !fl && m_vis[m];
            oe  = si && !fl && (m_cnt[m] == DEPTH);
            ue  = so && !fl && !m_vis[m];
            if (wr) exp_q[m].push_back(di);
            n_cnt[m] = fl ? 0 : m_cnt[m] + int'(wr) - int'(pop);
            if (fl)
                n_vis[m] = 1'b0;
            else if (m == 0)
                n_vis[m] = (n_cnt[m] != 0);
            else
                // Prefetched head: only words stored before this edge count.
                n_vis[m] = ((m_cnt[m] - int'(pop)) != 0);
            n_ovf[m] = (m_ovf[m] && !ce) || oe;
            n_unf[m] = (m_unf[m] && !ce) || ue;
        end
        n_flush = fl;
        @(posedge clk);
        #2;
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = n_cnt[m]; m_vis[m] = n_vis[m];
            m_ovf[m] = n_ovf[m]; m_unf[m] = n_unf[m];
            if (n_flush) exp_q[m].delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            check({tag, "_level"}, m, 32'(o_level[m]), 32'd0);
            check({tag, "_empty"}, m, 32'(o_empty[m]), 32'd1);
            check({tag, "_full"},  m, 32'(o_full[m]),  32'd0);
            check({tag, "_ovf"},   m, 32'(o_ovf[m]),   32'd0);
            check({tag, "_unf"},   m, 32'(o_unf[m]),   32'd0);
            check({tag, "_dout"},  m, o_dout[m],       32'd0);
        end
    endtask

    // Monitor: compare status against the model and the head word against
    // the scoreboard; consume the head when the DUT presents it and it is popped.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int m = 0; m < 2; m++) begin
                    check("level", m, 32'(o_level[m]), 32'(m_cnt[m]));
                    check("empty", m, 32'(o_empty[m]), 32'(!m_vis[m]));
                    check("full",  m, 32'(o_full[m]),  32'(m_cnt[m] == DEPTH));
                    check("almost_full",  m, 32'(o_af[m]), 32'(m_cnt[m] >= af_t));
                    check("almost_empty", m, 32'(o_ae[m]), 32'(m_cnt[m] <= ae_t));
                    check("overflow",  m, 32'(o_ovf[m]), 32'(m_ovf[m]));
                    check("underflow", m, 32'(o_unf[m]), 32'(m_unf[m]));
                    if (!o_empty[m]) begin
                        if (exp_q[m].size() == 0) begin
                            check("head_present", m, 32'd1, 32'd0);
                        end else begin
                            check("d_out", m, o_dout[m], exp_q[m][0]);
                            if (cur_so && !cur_fl) void'(exp_q[m].pop_front());
                        end
                    end
                end
            end
        end
    end

    // Hard time bound in case the run stalls.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        if0.clr_err = 1'b0; if1.clr_err = 1'b0;
        set_thr(14, 2);
        model_clear();
        @(posedge clk); @(posedge clk); #2;
        check_reset_state("rst");
        for (int m = 0; m < 2; m++) begin
            check("rst_almost_full",  m, 32'(o_af[m]), 32'd0);
            check("rst_almost_empty", m, 32'(o_ae[m]), 32'd1);
        end
        set_thr(0, 2);
        #1;
        for (int m = 0; m < 2; m++) check("rst_af_thr0", m, 32'(o_af[m]), 32'd1);
        set_thr(14, 2);
        @(posedge clk); #2;
        res    = 1'b0;
        mon_en = 1'b1;

        // Single word through and out
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Fill past capacity, then drain in order
        for (int i = 0; i <= 16; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Prefill, then sustained simultaneous push/pop across the wrap
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(200 + i), 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 40; i++) cycle(1'b1, 32'(300 + i), 1'b1, 1'b0, 1'b0);

        // Drain past empty, clr_err racing a new underflow, then clr_err alone
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Flush beats simultaneous push and pop
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(500 + i), 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, 32'h0000AAAA, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Async reset between edges with data held and a flag set
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(700 + i), 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int m = 0; m < 2; m++) check("pre_rst_unf", m, 32'(o_unf[m]), 32'd1);
        mon_en = 1'b0;
        res    = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_clear();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        res    = 1'b0;
        mon_en = 1'b1;

        // Randomised traffic alternating fill-biased and drain-biased phases
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            pw = (ph % 2 == 0) ? 80 : 25;
            set_thr(int'($urandom_range(0, 20)), int'($urandom_range(0, 16)));
            for (int i = 0; i < 80; i++) begin
                cycle($urandom_range(0, 99) < pw, $urandom,
                      $urandom_range(0, 99) < (100 - pw),
                      $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < 4);
            end
        end
        idle(2);

        for (int m = 0; m < 2; m++)
            check("residual_words", m, 32'(exp_q[m].size()), 32'(m_cnt[m]));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
